mem_port_arbiter: RTL and testbench

Two-requester controller for the 256-byte data/instruction RAM. Arbitrates between the instruction-fetch port and the load/store port, checks alignment and range, then sequences the RAM's level-sensitive `E`/`RW`/`Size` interface with stable setup and strobe phases. Returns read data and a one-cycle acknowledge to the winning requester. Sits between the CPU pipeline's fetch and memory stages and the RAM instance.

---
 rtl/mem_port_arbiter_pkg.sv | 43 ++++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_rr_arb2.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DEF_MEM_BYTES = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  // Grant encoding doubles as the bit position in the one-hot grant vector.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } size_t;

  // Access as latched at grant time; drives the RAM bus directly.
  typedef struct packed {
    logic        rw;
    logic        size;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } req_t;

  // Misaligned word, or any byte of the access landing past the end of RAM.
  function automatic logic access_fault(input logic [8:0] addr, input logic size,
                                        input int mem_bytes);
    int w_end;
    w_end = int'(addr) + (size ? 4 : 1);
    return (size && (addr[1:0] != 2'b00)) || (w_end > mem_bytes);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the arbiter bundled together.
// Latency: n/a (wiring only).
// Backpressure: req held until the one-cycle ack.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_fault;

  logic        d_req;
  logic        d_rw;
  logic        d_size;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_fault;

  logic        mem_E;
  logic        mem_RW;
  logic [8:0]  mem_A;
  logic [31:0] mem_DataIn;
  logic        mem_Size;
  logic [31:0] mem_DataOut;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_DataOut,
    output if_ack, if_rdata, if_fault, d_ack, d_rdata, d_fault,
           mem_E, mem_RW, mem_A, mem_DataIn, mem_Size
  );

  // Pipeline + RAM side.
  modport master (
    output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_DataOut,
    input  if_ack, if_rdata, if_fault, d_ack, d_rdata, d_fault,
           mem_E, mem_RW, mem_A, mem_DataIn, mem_Size
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way picker: round-robin on ties (or data-first when RR_MODE=0).
// Latency: combinational grant; last_grant updates on the granting edge.
// Backpressure: grants only while i_gnt_en is high.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter bit RR_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req_if,
  input  logic       i_req_d,
  input  logic       i_gnt_en,
  output logic [1:0] o_gnt      // [1] = data port, [0] = fetch port
);

  gnt_t r_last;

  // Pick one requester; a lone requester always wins.
  always_comb begin
    o_gnt = 2'b00;
    if (i_gnt_en) begin
      if (i_req_if && i_req_d) begin
        if (RR_MODE && (r_last == GNT_D)) o_gnt = 2'b01;
        else                              o_gnt = 2'b10;
      end else if (i_req_d) begin
        o_gnt = 2'b10;
      end else if (i_req_if) begin
        o_gnt = 2'b01;
      end
    end
  end

  // Remember who won; starts at fetch so data takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_last <= GNT_IF;
    else if (o_gnt[1]) r_last <= GNT_D;
    else if (o_gnt[0]) r_last <= GNT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs load/store onto the RAM with setup/strobe/done phases.
// Latency: ack 3 cycles after grant edge for RAM accesses, 1 for faults.
// Backpressure: requesters hold req until ack; one access per 4 cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter bit RR_MODE   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  state_t      r_state, w_next;
  gnt_t        r_port;
  req_t        r_req, w_req;
  logic [1:0]  w_gnt;
  logic        w_grant;
  logic        w_fault;
  logic [31:0] r_if_rdata, r_d_rdata;

  rr_arb2 #(.RR_MODE(RR_MODE)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req_if (bus.if_req),
    .i_req_d  (bus.d_req),
    .i_gnt_en (r_state == IDLE),
    .o_gnt    (w_gnt)
  );

  // Select the winning request and check it; fetches are always word reads.
  always_comb begin
    w_grant = |w_gnt;
    if (w_gnt[1]) begin
      w_req = '{rw: bus.d_rw, size: bus.d_size, addr: bus.d_addr, wdata: bus.d_wdata};
    end else begin
      w_req = '{rw: 1'b0, size: SZ_WORD, addr: bus.if_addr, wdata: 32'h0};
    end
    w_fault = access_fault(w_req.addr, w_req.size, MEM_BYTES);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: faults skip the RAM entirely.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_grant ? (w_fault ? FAULT : SETUP) : IDLE;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = DONE;
      DONE:    w_next = IDLE;
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; the RAM bus comes straight from the latched request.
  always_comb begin
    bus.mem_E      = (r_state == STROBE);
    bus.mem_A      = r_req.addr;
    bus.mem_RW     = r_req.rw;
    bus.mem_Size   = r_req.size;
    bus.mem_DataIn = r_req.wdata;
    bus.if_ack     = ((r_state == DONE) || (r_state == FAULT)) && (r_port == GNT_IF);
    bus.d_ack      = ((r_state == DONE) || (r_state == FAULT)) && (r_port == GNT_D);
    bus.if_fault   = (r_state == FAULT) && (r_port == GNT_IF);
    bus.d_fault    = (r_state == FAULT) && (r_port == GNT_D);
    bus.if_rdata   = r_if_rdata;
    bus.d_rdata    = r_d_rdata;
  end

  // Latch the granted access (bus only moves on legal grants) and capture read data
  // at the end of the strobe so it is valid alongside ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port     <= GNT_IF;
      r_req      <= '0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      if ((r_state == IDLE) && w_grant) begin
        r_port <= w_gnt[1] ? GNT_D : GNT_IF;
        if (w_fault) begin
          if (w_gnt[1]) r_d_rdata  <= 32'h0;
          else          r_if_rdata <= 32'h0;
        end else begin
          r_req <= w_req;
        end
      end
      if ((r_state == STROBE) && !r_req.rw) begin
        if (r_port == GNT_D) r_d_rdata  <= bus.mem_DataOut;
        else                 r_if_rdata <= bus.mem_DataOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed accesses plus random legal traffic.
// Expected acks queued at issue, popped by a monitor on each ack.
// RAM strobes checked against a second queue plus bus-hold checks.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    bit          port;    // 1 = data, 0 = fetch
    bit          fault;
    bit          chk;     // compare rdata
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [8:0]  a;
    bit          rw;
    bit          size;
    logic [31:0] wd;
  } ram_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pr_if_acks = 0;
  int   pr_d_acks = 0;

  exp_t sb_q[$];
  ram_t ram_q[$];
  logic [7:0] ram[256];
  logic [7:0] sh[256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_port_arbiter_if bus_rr();
  mem_port_arbiter_if bus_pr();

  mem_port_arbiter #(.MEM_BYTES(256), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .reset(reset), .bus(bus_rr)
  );
  mem_port_arbiter #(.MEM_BYTES(256), .RR_MODE(1'b0)) u_pr (
    .clk(clk), .reset(reset), .bus(bus_pr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural RAM: little-endian words, zero-extended bytes, write at end of strobe.
  always_comb begin
    logic [7:0] a;
    a = bus_rr.mem_A[7:0];
    if (bus_rr.mem_Size) bus_rr.mem_DataOut = {ram[a + 8'd3], ram[a + 8'd2], ram[a + 8'd1], ram[a]};
    else                 bus_rr.mem_DataOut = {24'h0, ram[a]};
  end

  always @(posedge clk) begin
    logic [7:0] a;
    a = bus_rr.mem_A[7:0];
    if (bus_rr.mem_E && bus_rr.mem_RW) begin
      if (bus_rr.mem_Size) {ram[a + 8'd3], ram[a + 8'd2], ram[a + 8'd1], ram[a]} = bus_rr.mem_DataIn;
      else                 ram[a] = bus_rr.mem_DataIn[7:0];
    end
  end

  // Ack monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus_rr.if_ack || bus_rr.d_ack)) begin
      chk("ack_onehot", bus_rr.if_ack & bus_rr.d_ack, 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_port", bus_rr.d_ack, e.port);
        chk("ack_cycle", cyc, e.cyc);
        if (e.port) begin
          chk("d_fault", bus_rr.d_fault, e.fault);
          if (e.chk) chk("d_rdata", bus_rr.d_rdata, e.rdata);
        end else begin
          chk("if_fault", bus_rr.if_fault, e.fault);
          if (e.chk) chk("if_rdata", bus_rr.if_rdata, e.rdata);
        end
      end
    end
  end

  // RAM strobe and bus-stability monitor.
  logic [42:0] prev_bus, strobe_bus, snap;
  bit          prev_ok = 0;
  bit          chk_next = 0;
  always @(negedge clk) begin
    ram_t r;
    snap = {bus_rr.mem_A, bus_rr.mem_RW, bus_rr.mem_Size, bus_rr.mem_DataIn};
    if (reset) begin
      chk_next = 0;
      prev_ok  = 0;
    end else begin
      if (chk_next) begin
        chk("strobe_len", bus_rr.mem_E, 0);
        chk("bus_hold_done", snap, strobe_bus);
      end
      chk_next = 0;
      if (bus_rr.mem_E) begin
        if (ram_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          r = ram_q.pop_front();
          chk("mem_A", bus_rr.mem_A, r.a);
          chk("mem_RW", bus_rr.mem_RW, r.rw);
          chk("mem_Size", bus_rr.mem_Size, r.size);
          if (r.rw) chk("mem_DataIn", bus_rr.mem_DataIn, r.wd);
        end
        if (prev_ok) chk("bus_hold_setup", snap, prev_bus);
        strobe_bus = snap;
        chk_next   = 1;
      end
      prev_bus = snap;
      prev_ok  = 1;
    end
  end

  // Priority-mode instance: both ports request forever.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_pr.if_ack) pr_if_acks++;
      if (bus_pr.d_ack)  pr_d_acks++;
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctrl"}, {bus_rr.if_ack, bus_rr.if_fault, bus_rr.d_ack, bus_rr.d_fault,
                         bus_rr.mem_E, bus_rr.mem_RW, bus_rr.mem_Size}, 0);
    chk({tag, "_if_rdata"}, bus_rr.if_rdata, 0);
    chk({tag, "_d_rdata"}, bus_rr.d_rdata, 0);
    chk({tag, "_mem_A"}, bus_rr.mem_A, 0);
    chk({tag, "_mem_DataIn"}, bus_rr.mem_DataIn, 0);
  endtask

  task automatic push_exp(input bit port, input bit rw, input bit size, input logic [8:0] addr,
                          input logic [31:0] wd, input bit fault, input logic [31:0] rdata,
                          input int lat_base);
    exp_t e;
    ram_t r;
    e.port  = port;
    e.fault = fault;
    e.chk   = fault || !rw;
    e.rdata = fault ? 32'h0 : rdata;
    e.cyc   = lat_base + (fault ? 1 : 3);
    sb_q.push_back(e);
    if (!fault) begin
      r.a = addr; r.rw = rw; r.size = size; r.wd = wd;
      ram_q.push_back(r);
    end
  endtask

  task automatic do_req(input bit port, input bit rw, input bit size, input logic [8:0] addr,
                        input logic [31:0] wd, input bit fault, input logic [31:0] rdata);
    bit got;
    logic [7:0] b;
    @(posedge clk); #1;
    if (port) begin
      bus_rr.d_req = 1; bus_rr.d_rw = rw; bus_rr.d_size = size;
      bus_rr.d_addr = addr; bus_rr.d_wdata = wd;
      push_exp(1, rw, size, addr, wd, fault, rdata, cyc);
    end else begin
      bus_rr.if_req = 1; bus_rr.if_addr = addr;
      push_exp(0, 0, 1, addr, wd, fault, rdata, cyc);
    end
    b = addr[7:0];
    if (port && rw && !fault) begin
      if (size) {sh[b + 8'd3], sh[b + 8'd2], sh[b + 8'd1], sh[b]} = wd;
      else      sh[b] = wd[7:0];
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? bus_rr.d_ack : bus_rr.if_ack;
    end
    chk("req_ack_seen", got, 1);
    @(posedge clk); #1;
    if (port) bus_rr.d_req = 0;
    else      bus_rr.if_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'(i);
      sh[i]  = 8'(i);
    end
    bus_rr.if_req = 0; bus_rr.if_addr = 0;
    bus_rr.d_req = 0; bus_rr.d_rw = 0; bus_rr.d_size = 0; bus_rr.d_addr = 0; bus_rr.d_wdata = 0;
    bus_pr.if_req = 1; bus_pr.if_addr = 9'h004;
    bus_pr.d_req = 1; bus_pr.d_rw = 0; bus_pr.d_size = 1; bus_pr.d_addr = 9'h000; bus_pr.d_wdata = 0;
    bus_pr.mem_DataOut = 32'h0;

    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    reset = 0;

    // Both ports tie from reset: D, I, D, I, acks 4 cycles apart.
    @(posedge clk); #1;
    bus_rr.d_req = 1; bus_rr.d_rw = 0; bus_rr.d_size = 1; bus_rr.d_addr = 9'h040;
    bus_rr.if_req = 1; bus_rr.if_addr = 9'h080;
    push_exp(1, 0, 1, 9'h040, 0, 0, 32'h43424140, cyc);
    push_exp(0, 0, 1, 9'h080, 0, 0, 32'h83828180, cyc + 4);
    push_exp(1, 0, 1, 9'h040, 0, 0, 32'h43424140, cyc + 8);
    push_exp(0, 0, 1, 9'h080, 0, 0, 32'h83828180, cyc + 12);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    chk("tie_acks_done", sb_q.size(), 0);
    #1;
    bus_rr.d_req = 0; bus_rr.if_req = 0;
    sb_q.delete(); ram_q.delete();

    // Directed data-port accesses.
    do_req(1, 1, 1, 9'h010, 32'hDEADBEEF, 0, 32'h0);
    do_req(1, 0, 1, 9'h010, 32'h0, 0, 32'hDEADBEEF);
    do_req(1, 1, 0, 9'h0FF, 32'h123456A5, 0, 32'h0);
    do_req(1, 0, 0, 9'h0FF, 32'h0, 0, 32'h000000A5);
    do_req(1, 0, 1, 9'h006, 32'h0, 1, 32'h0);
    do_req(1, 0, 0, 9'h100, 32'h0, 1, 32'h0);
    do_req(1, 1, 0, 9'h100, 32'h11111111, 1, 32'h0);
    do_req(1, 0, 1, 9'h0FD, 32'h0, 1, 32'h0);
    do_req(1, 0, 1, 9'h0FC, 32'h0, 0, 32'hA5FEFDFC);
    do_req(1, 1, 0, 9'h000, 32'hFFFFFF77, 0, 32'h0);
    do_req(1, 0, 1, 9'h000, 32'h0, 0, 32'h03020177);
    // Directed fetches.
    do_req(0, 0, 1, 9'h004, 32'h0, 0, 32'h07060504);
    do_req(0, 0, 1, 9'h002, 32'h0, 1, 32'h0);
    do_req(0, 0, 1, 9'h004, 32'h0, 0, 32'h07060504);

    // Reset during the strobe of a fetch, then the held request retries.
    @(posedge clk); #1;
    bus_rr.if_req = 1; bus_rr.if_addr = 9'h020;
    push_exp(0, 0, 1, 9'h020, 0, 0, 32'h23222120, cyc);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus_rr.mem_E;
    end
    chk("fetch_strobe_seen", got, 1);
    #2 reset = 1;
    #1 chk_outs_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_in_reset", {bus_rr.if_ack, bus_rr.d_ack, bus_rr.mem_E}, 0);
    end
    chk("strobe_consumed", ram_q.size(), 0);
    sb_q.delete(); ram_q.delete();
    @(negedge clk);
    reset = 0;
    push_exp(0, 0, 1, 9'h020, 0, 0, 32'h23222120, cyc);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus_rr.if_ack;
    end
    chk("retry_ack_seen", got, 1);
    @(posedge clk); #1;
    bus_rr.if_req = 0;

    // Random legal traffic for bus stability and data integrity.
    for (int n = 0; n < 1000; n++) begin
      bit p, rw, sz;
      logic [8:0] a;
      logic [7:0] b;
      logic [31:0] wd, ex;
      p = 1'($urandom_range(0, 1));
      if (p) begin
        rw = 1'($urandom_range(0, 1));
        sz = 1'($urandom_range(0, 1));
      end else begin
        rw = 0;
        sz = 1;
      end
      if (sz) a = 9'($urandom_range(0, 63) * 4);
      else    a = 9'($urandom_range(0, 255));
      wd = $urandom;
      b  = a[7:0];
      ex = sz ? {sh[b + 8'd3], sh[b + 8'd2], sh[b + 8'd1], sh[b]} : {24'h0, sh[b]};
      do_req(p, rw, sz, a, wd, 0, ex);
    end

    repeat (4) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("ram_q_empty", ram_q.size(), 0);
    chk("pr_if_acks", pr_if_acks, 0);
    chk("pr_d_acks_nonzero", pr_d_acks != 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
